// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates icache reads and dcache reads/writes onto a single
//               RAM port, one transaction in flight, with fair alternation.
//               Optional counters enabled by defining ARB_STATS_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STAT_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              iwait,
  output logic              dwait,
  output logic [DATA_W-1:0] iload,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic [STAT_W-1:0] icount,
  output logic [STAT_W-1:0] dcount,
  output logic [STAT_W-1:0] stalls
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } state_t;

  state_t state, next_state;
  logic   last_d;
  logic   d_req;
  logic   i_done;
  logic   d_done;

  assign d_req  = dREN | dWEN;
  assign d_done = (state == DGNT) && d_req && (ramstate == RAM_ACCESS);
  assign i_done = (state == IGNT) && iREN  && (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b0;
    end else begin
      state <= next_state;
      if (d_done)
        last_d <= 1'b1;
      else if (i_done)
        last_d <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    iwait      = iREN;
    dwait      = d_req;
    iload      = '0;
    dload      = '0;
    case (state)
      IDLE: begin
        if (d_req && iREN)
          next_state = last_d ? IGNT : DGNT;
        else if (d_req)
          next_state = DGNT;
        else if (iREN)
          next_state = IGNT;
      end
      DGNT: begin
        // A dropped request aborts: strobes fall now, re-arbitrate next cycle.
        if (!d_req) begin
          next_state = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (dWEN)
            ramWEN = 1'b1;
          else
            ramREN = dREN;
          if (ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            dload      = ramload;
            next_state = IDLE;
          end
        end
      end
      IGNT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] icount_q;
  logic [STAT_W-1:0] dcount_q;
  logic [STAT_W-1:0] stalls_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
      stalls_q <= '0;
    end else begin
      if (i_done)
        icount_q <= icount_q + 1'b1;
      if (d_done)
        dcount_q <= dcount_q + 1'b1;
      if ((iREN | d_req) && (ramstate != RAM_ACCESS))
        stalls_q <= stalls_q + 1'b1;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
  assign stalls = stalls_q;
`else
  assign icount = '0;
  assign dcount = '0;
  assign stalls = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] icount, dcount, stalls;

  int chk = 0;
  int err = 0;
  logic [31:0] exp_i = 0, exp_d = 0, exp_s = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STAT_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .icount(icount), .dcount(dcount), .stalls(stalls)
  );

  always #5 CLK = ~CLK;

  // Advance one clock, updating the expected stall/reset model from the
  // inputs held across the edge; returns at the following falling edge.
  task automatic step();
    if (RST) begin
      exp_i = 0; exp_d = 0; exp_s = 0;
    end else if (STATS && (iREN | dREN | dWEN) && ramstate != 2'd2) begin
      exp_s = exp_s + 1;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1; iREN = 1; dREN = 1; dWEN = 0; iaddr = 32'h4; daddr = 32'h8;
    dstore = 32'h9; ramload = 32'h0; ramstate = 2'd0;
    step(); #1;
    chk++; if (ramREN !== 1'b0) begin err++; $display("FAIL rst_ren got=%0b exp=0", ramREN); end
    chk++; if (ramWEN !== 1'b0) begin err++; $display("FAIL rst_wen got=%0b exp=0", ramWEN); end
    chk++; if (ramaddr !== 32'h0) begin err++; $display("FAIL rst_addr got=%h exp=0", ramaddr); end
    step(); #1;
    chk++; if (iwait !== 1'b1 || dwait !== 1'b1) begin err++; $display("FAIL rst_waits got=%0b%0b exp=11", iwait, dwait); end
    chk++; if (iload !== 32'h0 || dload !== 32'h0 || ramstore !== 32'h0) begin err++; $display("FAIL rst_loads got=%h/%h/%h exp=0", iload, dload, ramstore); end
    chk++; if (icount !== 32'h0 || dcount !== 32'h0 || stalls !== 32'h0) begin err++; $display("FAIL rst_counters got=%0d/%0d/%0d exp=0", icount, dcount, stalls); end
    RST = 0; iREN = 0; dREN = 0; #1;
    chk++; if (iwait !== 1'b0 || dwait !== 1'b0) begin err++; $display("FAIL rst_idle_waits got=%0b%0b exp=00", iwait, dwait); end
  endtask

  task automatic test_lone_icache();
    @(negedge CLK);
    iREN = 1; iaddr = 32'h100; ramstate = 2'd0; #1;
    chk++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin err++; $display("FAIL li_idle got iwait=%0b ren=%0b exp 1/0", iwait, ramREN); end
    step(); ramstate = 2'd1; #1;
    chk++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h100) begin err++; $display("FAIL li_grant got ren=%0b wen=%0b addr=%h exp 1/0/100", ramREN, ramWEN, ramaddr); end
    chk++; if (iwait !== 1'b1) begin err++; $display("FAIL li_busy_wait got=%0b exp=1", iwait); end
    step();
    step(); ramstate = 2'd2; ramload = 32'hDEADBEEF; #1;
    chk++; if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin err++; $display("FAIL li_done got iwait=%0b iload=%h exp 0/deadbeef", iwait, iload); end
    if (STATS) exp_i++;
    step(); iREN = 0; ramstate = 2'd0; ramload = 32'h0; #1;
    chk++; if (ramREN !== 1'b0 || iload !== 32'h0) begin err++; $display("FAIL li_after got ren=%0b iload=%h exp 0/0", ramREN, iload); end
    chk++; if (icount !== exp_i || stalls !== exp_s) begin err++; $display("FAIL li_counts got i=%0d s=%0d exp i=%0d s=%0d", icount, stalls, exp_i, exp_s); end
  endtask

  task automatic test_simultaneous();
    RST = 1; step(); RST = 0;
    iREN = 1; iaddr = 32'h300; dWEN = 1; daddr = 32'h200; dstore = 32'h55; ramstate = 2'd0; #1;
    chk++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin err++; $display("FAIL sim_idle got wen=%0b dw=%0b iw=%0b exp 0/1/1", ramWEN, dwait, iwait); end
    step(); ramstate = 2'd2; #1;
    chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'h55) begin err++; $display("FAIL sim_dgnt got wen=%0b ren=%0b addr=%h st=%h exp 1/0/200/55", ramWEN, ramREN, ramaddr, ramstore); end
    chk++; if (dwait !== 1'b0 || iwait !== 1'b1) begin err++; $display("FAIL sim_ddone got dw=%0b iw=%0b exp 0/1", dwait, iwait); end
    if (STATS) exp_d++;
    step(); ramstate = 2'd0; #1;
    chk++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || dwait !== 1'b1) begin err++; $display("FAIL sim_bubble got wen=%0b ren=%0b dw=%0b exp 0/0/1", ramWEN, ramREN, dwait); end
    step(); ramstate = 2'd2; ramload = 32'h1234; #1;
    chk++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h300) begin err++; $display("FAIL sim_igrant got ren=%0b wen=%0b addr=%h exp 1/0/300", ramREN, ramWEN, ramaddr); end
    chk++; if (iwait !== 1'b0 || iload !== 32'h1234 || dwait !== 1'b1) begin err++; $display("FAIL sim_idone got iw=%0b iload=%h dw=%0b exp 0/1234/1", iwait, iload, dwait); end
    if (STATS) exp_i++;
    step(); iREN = 0; dWEN = 0; ramstate = 2'd0; #1;
    chk++; if (icount !== exp_i || dcount !== exp_d || stalls !== exp_s) begin err++; $display("FAIL sim_counts got %0d/%0d/%0d exp %0d/%0d/%0d", icount, dcount, stalls, exp_i, exp_d, exp_s); end
  endtask

  task automatic test_write_priority();
    dREN = 1; dWEN = 1; daddr = 32'h44; dstore = 32'hA5; ramstate = 2'd0;
    step(); ramstate = 2'd1; #1;
    chk++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h44) begin err++; $display("FAIL wp_strobes got wen=%0b ren=%0b addr=%h exp 1/0/44", ramWEN, ramREN, ramaddr); end
    step(); ramstate = 2'd2; ramload = 32'h77; #1;
    chk++; if (dwait !== 1'b0 || dload !== 32'h77) begin err++; $display("FAIL wp_done got dw=%0b dload=%h exp 0/77", dwait, dload); end
    if (STATS) exp_d++;
    step(); dREN = 0; dWEN = 0; ramstate = 2'd0; ramload = 32'h0;
  endtask

  task automatic test_abort();
    @(negedge CLK);
    dREN = 1; daddr = 32'h40; ramstate = 2'd0;
    step(); ramstate = 2'd1; #1;
    chk++; if (ramREN !== 1'b1) begin err++; $display("FAIL ab_grant got ren=%0b exp=1", ramREN); end
    step(); dREN = 0; #1;
    chk++; if (ramREN !== 1'b0 || dwait !== 1'b0) begin err++; $display("FAIL ab_drop got ren=%0b dw=%0b exp 0/0", ramREN, dwait); end
    step(); dREN = 1; #1;
    chk++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin err++; $display("FAIL ab_idle got ren=%0b dw=%0b exp 0/1", ramREN, dwait); end
    step(); dREN = 0; step(); ramstate = 2'd0; #1;
    chk++; if (dcount !== exp_d || stalls !== exp_s) begin err++; $display("FAIL ab_counts got d=%0d s=%0d exp d=%0d s=%0d", dcount, stalls, exp_d, exp_s); end
  endtask

  task automatic test_error();
    @(negedge CLK);
    dREN = 1; daddr = 32'h80; ramstate = 2'd0;
    step();
    for (int n = 0; n < 5; n++) begin
      ramstate = 2'd3; #1;
      chk++; if (dwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h80) begin err++; $display("FAIL err_hold%0d got dw=%0b ren=%0b addr=%h exp 1/1/80", n, dwait, ramREN, ramaddr); end
      step();
    end
    ramstate = 2'd2; ramload = 32'hCAFE; #1;
    chk++; if (dwait !== 1'b0 || dload !== 32'hCAFE) begin err++; $display("FAIL err_done got dw=%0b dload=%h exp 0/cafe", dwait, dload); end
    if (STATS) exp_d++;
    step(); dREN = 0; ramstate = 2'd0; #1;
    chk++; if (dcount !== exp_d || stalls !== exp_s) begin err++; $display("FAIL err_counts got d=%0d s=%0d exp d=%0d s=%0d", dcount, stalls, exp_d, exp_s); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    dREN = 1; daddr = 32'h90; ramstate = 2'd0;
    step(); ramstate = 2'd1; #1;
    chk++; if (ramREN !== 1'b1) begin err++; $display("FAIL rm_grant got ren=%0b exp=1", ramREN); end
    RST = 1; step(); #1;
    chk++; if (ramREN !== 1'b0 || ramaddr !== 32'h0 || dwait !== 1'b1) begin err++; $display("FAIL rm_state got ren=%0b addr=%h dw=%0b exp 0/0/1", ramREN, ramaddr, dwait); end
    chk++; if (icount !== 32'h0 || dcount !== 32'h0 || stalls !== 32'h0) begin err++; $display("FAIL rm_counts got %0d/%0d/%0d exp 0", icount, dcount, stalls); end
    RST = 0; dREN = 0; ramstate = 2'd0;
  endtask

  task automatic test_back_to_back();
    RST = 1; step(); RST = 0;
    dREN = 1; iREN = 1; daddr = 32'h10; iaddr = 32'h20; ramstate = 2'd2;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk++; if (ramREN !== 1'b0 || iwait !== 1'b1 || dwait !== 1'b1) begin err++; $display("FAIL b2b_bubble%0d got ren=%0b iw=%0b dw=%0b exp 0/1/1", k, ramREN, iwait, dwait); end
      step(); ramload = 32'h1000 + k; #1;
      if (k % 2 == 0) begin
        chk++; if (ramaddr !== 32'h10 || dwait !== 1'b0 || iwait !== 1'b1 || dload !== ramload) begin err++; $display("FAIL b2b_d%0d got addr=%h dw=%0b iw=%0b dload=%h exp 10/0/1/%h", k, ramaddr, dwait, iwait, dload, 32'h1000 + k); end
        if (STATS) exp_d++;
      end else begin
        chk++; if (ramaddr !== 32'h20 || iwait !== 1'b0 || dwait !== 1'b1 || iload !== ramload) begin err++; $display("FAIL b2b_i%0d got addr=%h iw=%0b dw=%0b iload=%h exp 20/0/1/%h", k, ramaddr, iwait, dwait, iload, 32'h1000 + k); end
        if (STATS) exp_i++;
      end
      step();
    end
    dREN = 0; iREN = 0; ramstate = 2'd0; #1;
    chk++; if (icount !== (STATS ? 32'd4 : 32'd0) || dcount !== (STATS ? 32'd4 : 32'd0)) begin err++; $display("FAIL b2b_counts got i=%0d d=%0d exp 4/4 (0/0 without stats)", icount, dcount); end
    chk++; if (stalls !== exp_s) begin err++; $display("FAIL b2b_stalls got=%0d exp=%0d", stalls, exp_s); end
  endtask

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ramstate = 0;
    @(negedge CLK);
    test_reset();
    test_lone_icache();
    test_simultaneous();
    test_write_priority();
    test_abort();
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
